// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_pkg
// Brief    : Operand classes and helpers shared by the floating-point units.
// Revision : 1.0
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Subnormals (e=0, m!=0) classify as ZERO: the datapath treats them as zero.
    function automatic fp_class_e fp_classify(input logic [31:0] e,
                                              input logic [63:0] m,
                                              input int          exp_w);
        logic [31:0] ones;
        ones = (32'd1 << exp_w) - 32'd1;
        if (e == 32'd0)
            return ZERO;
        else if (e == ones)
            return (m == 64'd0) ? INF : NAN;
        return NORM;
    endfunction

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan_man(input int man_w);
        return 64'd1 << (man_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Brief    : Leading-zero counter; returns WIDTH for an all-zero input.
// Revision : 1.0
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Later iterations win, so the highest set bit decides the count.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i])
                o_count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_pipe
// Brief    : Three-stage pipelined floating-point adder, round-to-nearest-even,
//            DAZ/FTZ, valid/ready handshake with a shared stage enable.
// Revision : 1.0
// ============================================================================
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             sa_i,
    input  logic [EXP_W-1:0] ea_i,
    input  logic [MAN_W-1:0] ma_i,
    input  logic             sb_i,
    input  logic [EXP_W-1:0] eb_i,
    input  logic [MAN_W-1:0] mb_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             s_o,
    output logic [EXP_W-1:0] e_o,
    output logic [MAN_W-1:0] m_o
);

    localparam int               c_SIG_W     = MAN_W + 4;
    localparam int               c_SUM_W     = MAN_W + 5;
    localparam int               c_LZC_W     = $clog2(c_SIG_W + 1);
    localparam int               c_XE_W      = EXP_W + 2;
    localparam logic [EXP_W-1:0] c_EXP_ONES  = '1;
    localparam logic [63:0]      c_QNAN_WIDE = fp_qnan_man(MAN_W);
    localparam logic [MAN_W-1:0] c_QNAN_MAN  = c_QNAN_WIDE[MAN_W-1:0];

    logic w_adv;
    logic r1_v, r2_v, r3_v;

    assign w_adv   = ready_i | ~r3_v;
    assign ready_o = w_adv;

    // ---------------- stage 1: classify, swap, align ----------------
    fp_class_e            w_cls_a, w_cls_b;
    logic [EXP_W-1:0]     w_ea, w_eb, w_el, w_es, w_diff, w_shamt;
    logic [MAN_W-1:0]     w_ma, w_mb, w_ml, w_ms;
    logic                 w_swap, w_sl, w_ss;
    logic [c_SIG_W-1:0]   w_ext_s, w_sig_s;
    logic [2*c_SIG_W-1:0] w_wide;
    logic                 w_nan, w_inf, w_zz;
    logic                 w_spec_s;
    logic [EXP_W-1:0]     w_spec_e;
    logic [MAN_W-1:0]     w_spec_m;

    always_comb begin
        w_cls_a = fp_classify(32'(ea_i), 64'(ma_i), EXP_W);
        w_cls_b = fp_classify(32'(eb_i), 64'(mb_i), EXP_W);
        w_ea    = (w_cls_a == ZERO) ? '0 : ea_i;
        w_ma    = (w_cls_a == ZERO) ? '0 : ma_i;
        w_eb    = (w_cls_b == ZERO) ? '0 : eb_i;
        w_mb    = (w_cls_b == ZERO) ? '0 : mb_i;
        w_swap  = {w_eb, w_mb} > {w_ea, w_ma};
        w_sl    = w_swap ? sb_i : sa_i;
        w_ss    = w_swap ? sa_i : sb_i;
        w_el    = w_swap ? w_eb : w_ea;
        w_ml    = w_swap ? w_mb : w_ma;
        w_es    = w_swap ? w_ea : w_eb;
        w_ms    = w_swap ? w_ma : w_mb;
        w_diff  = w_el - w_es;
        w_shamt = (w_diff > EXP_W'(c_SIG_W)) ? EXP_W'(c_SIG_W) : w_diff;
        // Lower half of the double-width shift collects everything shifted out.
        w_ext_s = {|w_es, w_ms, 3'b000};
        w_wide  = {w_ext_s, {c_SIG_W{1'b0}}} >> w_shamt;
        w_sig_s = {w_wide[2*c_SIG_W-1:c_SIG_W+1],
                   w_wide[c_SIG_W] | (|w_wide[c_SIG_W-1:0])};

        w_nan = (w_cls_a == NAN) | (w_cls_b == NAN) |
                ((w_cls_a == INF) & (w_cls_b == INF) & (sa_i != sb_i));
        w_inf = (w_cls_a == INF) | (w_cls_b == INF);
        w_zz  = (w_cls_a == ZERO) & (w_cls_b == ZERO);
        if (w_nan) begin
            w_spec_s = 1'b0;
            w_spec_e = c_EXP_ONES;
            w_spec_m = c_QNAN_MAN;
        end else if (w_inf) begin
            w_spec_s = (w_cls_a == INF) ? sa_i : sb_i;
            w_spec_e = c_EXP_ONES;
            w_spec_m = '0;
        end else begin
            w_spec_s = sa_i & sb_i;
            w_spec_e = '0;
            w_spec_m = '0;
        end
    end

    logic               r1_spec, r1_ss, r1_sign, r1_sub;
    logic [EXP_W-1:0]   r1_se, r1_exp;
    logic [MAN_W-1:0]   r1_sm;
    logic [c_SIG_W-1:0] r1_sig_l, r1_sig_s;

    // ---------------- stage 2: add / subtract, leading zeros ----------------
    logic [c_SUM_W-1:0] w_sum;
    logic [c_LZC_W-1:0] w_lzc;

    assign w_sum = r1_sub ? ({1'b0, r1_sig_l} - {1'b0, r1_sig_s})
                          : ({1'b0, r1_sig_l} + {1'b0, r1_sig_s});

    fp_lzc #(
        .WIDTH (c_SIG_W),
        .CNT_W (c_LZC_W)
    ) u_lzc (
        .i_data  (w_sum[c_SIG_W-1:0]),
        .o_count (w_lzc)
    );

    logic               r2_spec, r2_ss, r2_sign;
    logic [EXP_W-1:0]   r2_se, r2_exp;
    logic [MAN_W-1:0]   r2_sm;
    logic [c_SUM_W-1:0] r2_sum;
    logic [c_LZC_W-1:0] r2_lzc;

    // ---------------- stage 3: normalise, round, range ----------------
    logic [c_SIG_W-1:0] w_norm;
    logic [c_XE_W-1:0]  w_xe, w_xe_rnd;
    logic               w_rup;
    logic [MAN_W:0]     w_rnd;
    logic               w_s3;
    logic [EXP_W-1:0]   w_e3;
    logic [MAN_W-1:0]   w_m3;

    always_comb begin
        if (r2_sum[c_SUM_W-1]) begin
            w_norm = {r2_sum[c_SUM_W-1:2], |r2_sum[1:0]};
            w_xe   = {2'b00, r2_exp} + c_XE_W'(1);
        end else begin
            w_norm = r2_sum[c_SIG_W-1:0] << r2_lzc;
            w_xe   = {2'b00, r2_exp} - c_XE_W'(r2_lzc);
        end
        w_rup    = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_rnd    = {1'b0, w_norm[c_SIG_W-2:3]} + (MAN_W + 1)'(w_rup);
        w_xe_rnd = w_rnd[MAN_W] ? (w_xe + c_XE_W'(1)) : w_xe;

        w_s3 = r2_sign;
        w_e3 = w_xe_rnd[EXP_W-1:0];
        w_m3 = w_rnd[MAN_W-1:0];
        // A clear hidden bit after normalisation means the sum was exactly zero.
        if (r2_spec) begin
            w_s3 = r2_ss;
            w_e3 = r2_se;
            w_m3 = r2_sm;
        end else if (!w_norm[c_SIG_W-1]) begin
            w_s3 = 1'b0;
            w_e3 = '0;
            w_m3 = '0;
        end else if (w_xe_rnd[c_XE_W-1] || (w_xe_rnd == '0)) begin
            w_e3 = '0;
            w_m3 = '0;
        end else if (w_xe_rnd >= {2'b00, c_EXP_ONES}) begin
            w_e3 = c_EXP_ONES;
            w_m3 = '0;
        end
    end

    logic             r3_s;
    logic [EXP_W-1:0] r3_e;
    logic [MAN_W-1:0] r3_m;

    // ---------------- stage registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v <= 1'b0;
            r2_v <= 1'b0;
            r3_v <= 1'b0;
        end else if (w_adv) begin
            r1_v <= valid_i;
            r2_v <= r1_v;
            r3_v <= r2_v;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_spec  <= w_nan | w_inf | w_zz;
            r1_ss    <= w_spec_s;
            r1_se    <= w_spec_e;
            r1_sm    <= w_spec_m;
            r1_sign  <= w_sl;
            r1_sub   <= w_sl ^ w_ss;
            r1_exp   <= w_el;
            r1_sig_l <= {|w_el, w_ml, 3'b000};
            r1_sig_s <= w_sig_s;

            r2_spec  <= r1_spec;
            r2_ss    <= r1_ss;
            r2_se    <= r1_se;
            r2_sm    <= r1_sm;
            r2_sign  <= r1_sign;
            r2_exp   <= r1_exp;
            r2_sum   <= w_sum;
            r2_lzc   <= w_lzc;

            r3_s     <= w_s3;
            r3_e     <= w_e3;
            r3_m     <= w_m3;
        end
    end

    assign valid_o = r3_v;
    assign s_o     = r3_v & r3_s;
    assign e_o     = {EXP_W{r3_v}} & r3_e;
    assign m_o     = {MAN_W{r3_v}} & r3_m;

endmodule
`default_nettype wire
